// File: rtl/cdr_pkg.sv
// Shared CDR loop definitions.
// Provides the sequencer state encoding, the decision direction encoding,
// the default loop parameters and the per-state output flag decode used by
// phase_code_ctrl. No ports; imported by the interface, the controller and
// any future CDR sequencer.
package cdr_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  // Direction of a decision; DIR_NONE also marks "no predecessor yet"
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  // Status flags derived from the state, kept in one register
  typedef struct packed {
    logic idle;
    logic acq_done;
    logic locked;
  } flags_t;

  localparam int DEF_CODE_W     = 6;
  localparam int DEF_ACQ_STEP   = 4;
  localparam int DEF_SETTLE_CYC = 3;
  localparam int DEF_LOCK_REV   = 8;

  // True when the current decision reverses a known previous one
  function automatic logic is_reversal(input dir_t last, input dir_t cur);
    return (last != DIR_NONE) && (cur != DIR_NONE) && (last != cur);
  endfunction

  // Status flags that a given state presents on the outputs
  function automatic flags_t flags_of(input state_t s);
    flags_t f;
    case (s)
      ST_IDLE:  f = '{idle: 1'b1, acq_done: 1'b0, locked: 1'b0};
      ST_ACQ:   f = '{idle: 1'b0, acq_done: 1'b0, locked: 1'b0};
      ST_TRACK: f = '{idle: 1'b0, acq_done: 1'b1, locked: 1'b0};
      ST_LOCK:  f = '{idle: 1'b0, acq_done: 1'b1, locked: 1'b1};
      default:  f = '{idle: 1'b1, acq_done: 1'b0, locked: 1'b0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/phase_code_ctrl_if.sv
// Bus between the vote FSM / loop supervisor and the PI code controller.
// master : drives en, up, down, load, load_code; observes the status outputs.
// slave  : the controller; consumes decisions, drives pi_code, vote_clr,
//          locked and acq_done.
interface phase_code_ctrl_if import cdr_pkg::*; #(
  parameter int CODE_W = DEF_CODE_W
) ();

  logic              en;
  logic              up;
  logic              down;
  logic              load;
  logic [CODE_W-1:0] load_code;
  logic [CODE_W-1:0] pi_code;
  logic              vote_clr;
  logic              locked;
  logic              acq_done;

  modport master (
    output en, up, down, load, load_code,
    input  pi_code, vote_clr, locked, acq_done
  );

  modport slave (
    input  en, up, down, load, load_code,
    output pi_code, vote_clr, locked, acq_done
  );

endinterface

// File: rtl/holdoff_timer.sv
// Reloadable down-counter that keeps a consumer off the loop while an analog
// block settles.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : restart the hold-off with load_val cycles
//   load_val   : hold-off length in cycles (0 means no hold-off)
//   busy       : registered, high while the hold-off is running
module holdoff_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;

  // Remaining hold-off cycles; a reload always wins over the down-count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // busy mirrors "count will be nonzero", so it is high exactly load_val cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else if (load) begin
      busy_r <= (load_val != '0);
    end else begin
      busy_r <= (cnt_r > CNT_W'(1));
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/phase_code_ctrl.sv
// Phase interpolator code sequencer for the XAUI receive CDR loop.
// Turns one-cycle up/down decisions from the vote FSM into a circular PI
// code: coarse ACQ_STEP moves until the first reversal, then single-LSB
// tracking, with lock declared after LOCK_REV consecutive reversals. Every
// code change holds the vote FSM in clear for SETTLE_CYC cycles.
// Ports:
//   clk_cont : loop clock shared with the vote FSM
//   rst_n    : asynchronous active-low reset
//   bus      : phase_code_ctrl_if.slave (en, up, down, load, load_code in;
//              pi_code, vote_clr, locked, acq_done out, all registered)
module phase_code_ctrl import cdr_pkg::*; #(
  parameter int CODE_W     = DEF_CODE_W,
  parameter int ACQ_STEP   = DEF_ACQ_STEP,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOCK_REV   = DEF_LOCK_REV
) (
  input  logic               clk_cont,
  input  logic               rst_n,
  phase_code_ctrl_if.slave   bus
);

  localparam int HOLD_W = $clog2(SETTLE_CYC + 1);
  localparam int REV_W  = $clog2(LOCK_REV + 1);

  state_t            state_r;
  flags_t            flags_r;
  logic [CODE_W-1:0] code_r;
  logic [REV_W-1:0]  rev_r;
  dir_t              last_r;

  dir_t              dir_s;
  logic              rev_s;
  logic              accept_s;
  logic              hold_load_s;
  logic              busy_s;
  logic [CODE_W-1:0] step_s;
  logic [CODE_W-1:0] stepped_code_s;
  logic [REV_W-1:0]  rev_inc_s;

  // Decode the decision pulses; a simultaneous up and down carries no direction
  always_comb begin
    dir_s = DIR_NONE;
    if (bus.up && !bus.down) begin
      dir_s = DIR_UP;
    end else if (bus.down && !bus.up) begin
      dir_s = DIR_DN;
    end else begin
      dir_s = DIR_NONE;
    end
  end

  assign rev_s     = is_reversal(last_r, dir_s);
  assign accept_s  = (state_r != ST_IDLE) && !busy_s && (dir_s != DIR_NONE);
  assign rev_inc_s = rev_r + REV_W'(1);

  // Hold-off restarts on a load, on leaving IDLE, and on every accepted step
  assign hold_load_s = bus.load
                     | (bus.en && (state_r == ST_IDLE))
                     | (bus.en && accept_s);

  // Next code for the current decision; modulo wrap comes from CODE_W truncation.
  // The reversal that ends acquisition is already a fine step.
  always_comb begin
    step_s = CODE_W'(1);
    if ((state_r == ST_ACQ) && !rev_s) begin
      step_s = CODE_W'(ACQ_STEP);
    end else begin
      step_s = CODE_W'(1);
    end
    case (dir_s)
      DIR_UP:  stepped_code_s = code_r + step_s;
      DIR_DN:  stepped_code_s = code_r - step_s;
      default: stepped_code_s = code_r;
    endcase
  end

  holdoff_timer #(
    .CNT_W (HOLD_W)
  ) u_holdoff (
    .clk      (clk_cont),
    .rst_n    (rst_n),
    .load     (hold_load_s),
    .load_val (HOLD_W'(SETTLE_CYC)),
    .busy     (busy_s)
  );

  // Sequencer FSM; status flags are registered alongside each state change
  always_ff @(posedge clk_cont or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      flags_r <= flags_of(ST_IDLE);
      code_r  <= '0;
      rev_r   <= '0;
      last_r  <= DIR_NONE;
    end else if (!bus.en) begin
      // Disabled: park in IDLE, forget reversal history; a load still presets the code
      state_r <= ST_IDLE;
      flags_r <= flags_of(ST_IDLE);
      rev_r   <= '0;
      last_r  <= DIR_NONE;
      if (bus.load) begin
        code_r <= bus.load_code;
      end else begin
        code_r <= code_r;
      end
    end else if (bus.load) begin
      // Forced code restarts acquisition with no predecessor decision
      state_r <= ST_ACQ;
      flags_r <= flags_of(ST_ACQ);
      code_r  <= bus.load_code;
      rev_r   <= '0;
      last_r  <= DIR_NONE;
    end else if (state_r == ST_IDLE) begin
      state_r <= ST_ACQ;
      flags_r <= flags_of(ST_ACQ);
    end else if (accept_s) begin
      code_r <= stepped_code_s;
      last_r <= dir_s;
      case (state_r)
        ST_ACQ: begin
          if (rev_s) begin
            state_r <= ST_TRACK;
            flags_r <= flags_of(ST_TRACK);
            rev_r   <= '0;
          end else begin
            state_r <= ST_ACQ;
            flags_r <= flags_of(ST_ACQ);
          end
        end
        ST_TRACK: begin
          if (rev_s) begin
            rev_r <= rev_inc_s;
            if (rev_inc_s == REV_W'(LOCK_REV)) begin
              state_r <= ST_LOCK;
              flags_r <= flags_of(ST_LOCK);
            end else begin
              state_r <= ST_TRACK;
              flags_r <= flags_of(ST_TRACK);
            end
          end else begin
            state_r <= ST_TRACK;
            flags_r <= flags_of(ST_TRACK);
            rev_r   <= '0;
          end
        end
        ST_LOCK: begin
          // A decision repeating its predecessor means the loop has drifted
          if (rev_s) begin
            state_r <= ST_LOCK;
            flags_r <= flags_of(ST_LOCK);
          end else begin
            state_r <= ST_TRACK;
            flags_r <= flags_of(ST_TRACK);
            rev_r   <= '0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          flags_r <= flags_of(ST_IDLE);
          rev_r   <= '0;
        end
      endcase
    end else begin
      state_r <= state_r;
      flags_r <= flags_r;
    end
  end

  assign bus.pi_code  = code_r;
  assign bus.locked   = flags_r.locked;
  assign bus.acq_done = flags_r.acq_done;
  // Both terms are flop outputs, so no input reaches vote_clr combinationally
  assign bus.vote_clr = flags_r.idle | busy_s;

endmodule

// File: tb/tb_phase_code_ctrl.sv
// Self-checking bench for phase_code_ctrl: directed scenarios against
// constants, then randomized traffic against an integer reference model.
module tb_phase_code_ctrl;

  localparam int CW     = 6;
  localparam int STEP   = 4;
  localparam int SETTLE = 3;
  localparam int LREV   = 8;
  localparam int MOD    = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phase_code_ctrl_if #(.CODE_W(CW)) bus ();

  phase_code_ctrl #(
    .CODE_W(CW), .ACQ_STEP(STEP), .SETTLE_CYC(SETTLE), .LOCK_REV(LREV)
  ) dut (
    .clk_cont (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 acquire, 2 track, 3 lock; last is +1/-1/0
  int m_mode, m_code, m_hold, m_last, m_rev;

  task automatic model_reset();
    m_mode = 0; m_code = 0; m_hold = 0; m_last = 0; m_rev = 0;
  endtask

  task automatic model_step(input bit e, input bit u, input bit d, input bit l, input int lc);
    int  dv;
    bit  rev;
    if (!e) begin
      m_mode = 0; m_rev = 0; m_last = 0;
      if (l) begin m_code = lc; m_hold = SETTLE; end
      else if (m_hold > 0) m_hold--;
    end else if (l) begin
      m_code = lc; m_mode = 1; m_rev = 0; m_last = 0; m_hold = SETTLE;
    end else if (m_mode == 0) begin
      m_mode = 1; m_hold = SETTLE;
    end else if (m_hold == 0 && u != d) begin
      dv  = u ? 1 : -1;
      rev = (m_last != 0) && (dv != m_last);
      if (m_mode == 1 && !rev) m_code = (m_code + dv * STEP + MOD) % MOD;
      else                     m_code = (m_code + dv + MOD) % MOD;
      if (m_mode == 1) begin
        if (rev) begin m_mode = 2; m_rev = 0; end
      end else if (m_mode == 2) begin
        if (rev) begin m_rev++; if (m_rev == LREV) m_mode = 3; end
        else m_rev = 0;
      end else begin
        if (!rev) begin m_mode = 2; m_rev = 0; end
      end
      m_last = dv; m_hold = SETTLE;
    end else if (m_hold > 0) begin
      m_hold--;
    end
  endtask

  // One clock: drive inputs, pass the edge, advance the model, sample 1 ns later
  task automatic cyc(input bit e, input bit u, input bit d, input bit l, input int lc);
    bus.en = e; bus.up = u; bus.down = d; bus.load = l; bus.load_code = lc[CW-1:0];
    @(posedge clk);
    if (rst_n) model_step(e, u, d, l, lc);
    #1;
  endtask

  task automatic settle();
    repeat (SETTLE) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = 0; bus.up = 0; bus.down = 0; bus.load = 0; bus.load_code = '0;
    model_reset();
    #12;
    checks += 4;
    if (bus.pi_code !== 6'd0)  begin errors++; $display("FAIL reset_pi_code: got %0d want 0", bus.pi_code); end
    if (bus.vote_clr !== 1'b1) begin errors++; $display("FAIL reset_vote_clr: got %b want 1", bus.vote_clr); end
    if (bus.locked !== 1'b0)   begin errors++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
    if (bus.acq_done !== 1'b0) begin errors++; $display("FAIL reset_acq_done: got %b want 0", bus.acq_done); end
    bus.en = 1; rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0);
    checks += 2;
    if (bus.vote_clr !== 1'b1) begin errors++; $display("FAIL enable_vote_clr: got %b want 1", bus.vote_clr); end
    if (bus.acq_done !== 1'b0) begin errors++; $display("FAIL enable_acq_done: got %b want 0", bus.acq_done); end
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    checks++;
    if (bus.vote_clr !== 1'b1) begin errors++; $display("FAIL enable_holdoff_2: got %b want 1", bus.vote_clr); end
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (bus.vote_clr !== 1'b0) begin errors++; $display("FAIL enable_holdoff_end: got %b want 0", bus.vote_clr); end
  endtask

  task automatic test_acquisition();
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (bus.pi_code !== 6'd4) begin errors++; $display("FAIL acq_up1: got %0d want 4", bus.pi_code); end
    settle();
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (bus.pi_code !== 6'd8) begin errors++; $display("FAIL acq_up2: got %0d want 8", bus.pi_code); end
    settle();
    cyc(1, 0, 1, 0, 0);
    checks += 3;
    if (bus.pi_code !== 6'd7)  begin errors++; $display("FAIL acq_reversal: got %0d want 7", bus.pi_code); end
    if (bus.acq_done !== 1'b1) begin errors++; $display("FAIL acq_done_rise: got %b want 1", bus.acq_done); end
    if (bus.locked !== 1'b0)   begin errors++; $display("FAIL acq_locked: got %b want 0", bus.locked); end
    settle();
  endtask

  task automatic test_wrap();
    cyc(1, 0, 0, 1, 2);
    checks += 2;
    if (bus.pi_code !== 6'd2)  begin errors++; $display("FAIL wrap_load: got %0d want 2", bus.pi_code); end
    if (bus.acq_done !== 1'b0) begin errors++; $display("FAIL wrap_load_acq: got %b want 0", bus.acq_done); end
    settle();
    cyc(1, 0, 1, 0, 0);
    checks++;
    if (bus.pi_code !== 6'd62) begin errors++; $display("FAIL wrap_down_acq: got %0d want 62", bus.pi_code); end
    settle();
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (bus.pi_code !== 6'd63) begin errors++; $display("FAIL wrap_to_max: got %0d want 63", bus.pi_code); end
    settle();
    cyc(1, 1, 0, 0, 0);
    checks += 2;
    if (bus.pi_code !== 6'd0)  begin errors++; $display("FAIL wrap_up_track: got %0d want 0", bus.pi_code); end
    if (bus.acq_done !== 1'b1) begin errors++; $display("FAIL wrap_track_acq: got %b want 1", bus.acq_done); end
    settle();
  endtask

  task automatic test_lock_unlock();
    cyc(1, 0, 1, 0, 0); settle();   // 63
    cyc(1, 0, 1, 0, 0); settle();   // 62, last direction now down, reversal count 0
    for (int i = 0; i < LREV; i++) begin
      cyc(1, (i % 2) == 0, (i % 2) != 0, 0, 0);
      checks += 2;
      if (bus.locked !== (i == LREV - 1)) begin
        errors++; $display("FAIL lock_step%0d: locked got %b want %b", i, bus.locked, (i == LREV - 1));
      end
      if (bus.pi_code !== (((i % 2) == 0) ? 6'd63 : 6'd62)) begin
        errors++; $display("FAIL lock_code%0d: got %0d", i, bus.pi_code);
      end
      settle();
    end
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_hold_rev: got %b want 1", bus.locked); end
    settle();
    cyc(1, 1, 0, 0, 0);
    checks += 3;
    if (bus.locked !== 1'b0)   begin errors++; $display("FAIL unlock: got %b want 0", bus.locked); end
    if (bus.acq_done !== 1'b1) begin errors++; $display("FAIL unlock_track: got %b want 1", bus.acq_done); end
    if (bus.pi_code !== 6'd0)  begin errors++; $display("FAIL unlock_code: got %0d want 0", bus.pi_code); end
    settle();
  endtask

  task automatic test_holdoff_conflict();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    checks += 2;
    if (bus.pi_code !== 6'd1)  begin errors++; $display("FAIL holdoff_drop: got %0d want 1", bus.pi_code); end
    if (bus.vote_clr !== 1'b1) begin errors++; $display("FAIL holdoff_vote_clr: got %b want 1", bus.vote_clr); end
    settle();
    cyc(1, 1, 1, 0, 0);
    checks += 2;
    if (bus.pi_code !== 6'd1)  begin errors++; $display("FAIL conflict_code: got %0d want 1", bus.pi_code); end
    if (bus.vote_clr !== 1'b0) begin errors++; $display("FAIL conflict_no_reload: got %b want 0", bus.vote_clr); end
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i <= SETTLE; i++) begin
      checks++;
      if (bus.vote_clr !== (i < SETTLE)) begin
        errors++; $display("FAIL holdoff_len%0d: got %b want %b", i, bus.vote_clr, (i < SETTLE));
      end
      if (i < SETTLE) cyc(1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_priority();
    cyc(1, 1, 0, 1, 40);
    checks += 2;
    if (bus.pi_code !== 6'd40) begin errors++; $display("FAIL prio_load_vs_up: got %0d want 40", bus.pi_code); end
    if (bus.acq_done !== 1'b0) begin errors++; $display("FAIL prio_load_acq: got %b want 0", bus.acq_done); end
    settle();
    cyc(1, 1, 0, 0, 0); settle();   // 44
    cyc(1, 0, 1, 0, 0); settle();   // 43, now tracking
    for (int i = 0; i < LREV; i++) begin
      cyc(1, (i % 2) == 0, (i % 2) != 0, 0, 0);
      settle();
    end
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL prio_relock: got %b want 1", bus.locked); end
    cyc(0, 1, 0, 0, 0);
    checks += 4;
    if (bus.locked !== 1'b0)   begin errors++; $display("FAIL disable_locked: got %b want 0", bus.locked); end
    if (bus.acq_done !== 1'b0) begin errors++; $display("FAIL disable_acq_done: got %b want 0", bus.acq_done); end
    if (bus.vote_clr !== 1'b1) begin errors++; $display("FAIL disable_vote_clr: got %b want 1", bus.vote_clr); end
    if (bus.pi_code !== 6'd43) begin errors++; $display("FAIL disable_code_held: got %0d want 43", bus.pi_code); end
  endtask

  task automatic test_random();
    bit u, d, e, l, nxt_up;
    int lc, r;
    nxt_up = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      e  = ($urandom_range(0, 99) < 97);
      l  = ($urandom_range(0, 99) < 2);
      lc = $urandom_range(0, MOD - 1);
      u  = 0; d = 0;
      r  = $urandom_range(0, 9);
      if (r == 9) begin
        u = 1; d = 1;
      end else if (m_hold == 0 && m_mode != 0 && r < 7) begin
        if ($urandom_range(0, 9) < 8) begin
          u = nxt_up; nxt_up = !nxt_up;
        end else begin
          u = !nxt_up;
        end
        d = !u;
      end else if (r == 8) begin
        u = $urandom_range(0, 1); d = !u;
      end
      cyc(e, u, d, l, lc);
      checks += 4;
      if (bus.pi_code !== m_code[CW-1:0]) begin
        errors++; $display("FAIL rand_pi_code@%0d: got %0d want %0d", n, bus.pi_code, m_code);
      end
      if (bus.vote_clr !== ((m_mode == 0) || (m_hold > 0))) begin
        errors++; $display("FAIL rand_vote_clr@%0d: got %b want %b", n, bus.vote_clr, ((m_mode == 0) || (m_hold > 0)));
      end
      if (bus.locked !== (m_mode == 3)) begin
        errors++; $display("FAIL rand_locked@%0d: got %b want %b", n, bus.locked, (m_mode == 3));
      end
      if (bus.acq_done !== (m_mode >= 2)) begin
        errors++; $display("FAIL rand_acq_done@%0d: got %b want %b", n, bus.acq_done, (m_mode >= 2));
      end
    end
  endtask

  task automatic test_reset_midstep();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 20);
    cyc(1, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks += 4;
    if (bus.pi_code !== 6'd0)  begin errors++; $display("FAIL midreset_pi_code: got %0d want 0", bus.pi_code); end
    if (bus.vote_clr !== 1'b1) begin errors++; $display("FAIL midreset_vote_clr: got %b want 1", bus.vote_clr); end
    if (bus.locked !== 1'b0)   begin errors++; $display("FAIL midreset_locked: got %b want 0", bus.locked); end
    if (bus.acq_done !== 1'b0) begin errors++; $display("FAIL midreset_acq_done: got %b want 0", bus.acq_done); end
    cyc(1, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (SETTLE + 1) cyc(1, 0, 0, 0, 0);
    checks += 2;
    if (bus.vote_clr !== 1'b0) begin errors++; $display("FAIL midreset_rearm: got %b want 0", bus.vote_clr); end
    if (bus.pi_code !== 6'd0)  begin errors++; $display("FAIL midreset_code: got %0d want 0", bus.pi_code); end
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (bus.pi_code !== 6'd4)  begin errors++; $display("FAIL midreset_first_step: got %0d want 4", bus.pi_code); end
  endtask

  initial begin
    test_reset();
    test_acquisition();
    test_wrap();
    test_lock_unlock();
    test_holdoff_conflict();
    test_priority();
    test_random();
    test_reset_midstep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
